// File: rtl/fpu_result_pkg.sv
// Shared types for the FPU result buffer.
// Defines the packed IEEE-754 single result, the exception flag bundle and the
// combined FIFO entry layout used between the top level and the result FIFO.
package fpu_result_pkg;

    localparam int unsigned FLAG_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } fpu_result_t;

    // One buffered result: data in the upper bits, flags in the lower bits.
    typedef struct packed {
        fpu_result_t result;
        fpu_flags_t  flags;
    } fpu_entry_t;

    localparam int unsigned ENTRY_W = $bits(fpu_entry_t);

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO for the FPU output buffer.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, wr_data  write request and entry
//   rd_en           pop request (ignored while empty)
//   rd_data         head entry, zero while empty
//   count           number of stored entries
//   full            count == DEPTH
//   wr_drop         write request rejected because the FIFO was full
// Storage is not reset; pointers and count are.
module fpu_result_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 37,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             wr_drop
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // A pop in the same cycle frees the slot, so a write into a full FIFO is
    // still accepted then; the head entry being replaced is the one leaving.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign wr_drop = wr_en && !do_wr;

    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/fpu_result_buffer.sv
// Output buffer at the end of the non-stallable FPU pipeline.
// Captures each result pulse into a FIFO and hands results to the consumer
// with valid/ready. A credit counter gates issue at the FPU input so every
// issued operation owns a buffer slot by the time its result emerges.
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   issue_valid, issue_ready  operation issue handshake at the FPU input
//   result_valid              one-cycle result pulse from the last stage
//   result_data, result_flags packed single result and exception flags
//   out_valid, out_ready      consumer handshake
//   out_data, out_flags       head result, zero while out_valid is low
//   outstanding               in-flight plus buffered operation count
//   overflow_err              sticky: a result arrived with the FIFO full
module fpu_result_buffer
    import fpu_result_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result_data,
    input  logic [FLAG_W-1:0] result_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [CNT_W-1:0]  outstanding,
    output logic              overflow_err
);

    fpu_entry_t       wr_entry;
    fpu_entry_t       rd_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_drop;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             overflow_q;

    assign wr_entry.result = fpu_result_t'(result_data);
    assign wr_entry.flags  = fpu_flags_t'(result_flags);

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (result_valid),
        .wr_data (wr_entry),
        .rd_en   (out_ready),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .wr_drop (fifo_drop)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = rd_entry.result;
    assign out_flags = rd_entry.flags;

    assign issue_ready = (outstanding_q < CNT_W'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign pop         = out_valid && out_ready;

    // The zero guard only matters if results were injected without credits.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (pop && !accept && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign outstanding  = outstanding_q;
    assign overflow_err = overflow_q;

    // Full status is implied by fifo_drop; kept visible for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
